// File: rtl/function_generator.sv
// Two-channel DDS function generator configured over an SPI-slave register port.
// SPI lines are synchronized into sys_clk and decoded by a small framing FSM.
//
//   state  | meaning
//   S_IDLE | no frame active; SCK ignored, MISO driven low
//   S_CMD  | shifting in byte0 {rw, addr[6:0]}; MISO presents ID_VALUE
//   S_DATA | data bytes; address auto-increments after each byte
module function_generator #(
    parameter int         OUT_W    = 12,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    output logic [OUT_W-1:0] dds_ch1_o,
    output logic [OUT_W-1:0] dds_ch2_o,
    input  logic             int_clk_i,
    input  logic             int_mosi_i,
    output logic             int_miso_o,
    input  logic             int_cs_i
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} spi_state_t;

    // Stage [2] of SCK/CS is the previous synchronized value for edge detection.
    logic [2:0]  sck_q, cs_q;
    logic [1:0]  mosi_q;
    logic        sck_rise, sck_fall, cs_fall, cs_rise;

    spi_state_t  state_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_sh_q;
    logic        rw_q;
    logic [6:0]  addr_q;
    logic [7:0]  miso_sh_q;
    logic        wr_en_q;
    logic [6:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic [7:0]  rd_data_d;

    logic [1:0]  ctrl_q, wave1_q, wave2_q;
    logic [31:0] ftw1_sh_q, ftw1_q, ftw2_sh_q, ftw2_q;
    logic [31:0] acc1_q, acc2_q, acc1_d, acc2_d;
    logic [OUT_W-1:0] ch1_q, ch2_q;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sck_q  <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], int_clk_i};
            cs_q   <= {cs_q[1:0], int_cs_i};
            mosi_q <= {mosi_q[0], int_mosi_i};
        end
    end

    assign sck_rise = sck_q[1] & ~sck_q[2];
    assign sck_fall = ~sck_q[1] & sck_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign cs_rise  = cs_q[1] & ~cs_q[2];

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rx_sh_q   <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            miso_sh_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (cs_rise) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= '0;
            end else if (cs_fall) begin
                state_q   <= S_CMD;
                bit_cnt_q <= '0;
                miso_sh_q <= ID_VALUE;
            end else if (state_q != S_IDLE) begin
                if (sck_rise) begin
                    rx_sh_q   <= {rx_sh_q[5:0], mosi_q[1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == S_CMD) begin
                            rw_q    <= rx_sh_q[6];
                            addr_q  <= {rx_sh_q[5:0], mosi_q[1]};
                            state_q <= S_DATA;
                        end else begin
                            wr_en_q   <= rw_q;
                            wr_addr_q <= addr_q;
                            wr_data_q <= {rx_sh_q, mosi_q[1]};
                            addr_q    <= addr_q + 7'd1;
                        end
                    end
                end else if (sck_fall) begin
                    // The fall after a completed byte loads the next reply byte instead of shifting.
                    if (state_q == S_DATA && bit_cnt_q == 3'd0)
                        miso_sh_q <= rw_q ? 8'h00 : rd_data_d;
                    else
                        miso_sh_q <= {miso_sh_q[6:0], 1'b0};
                end
            end
        end
    end

    assign int_miso_o = (state_q != S_IDLE) & miso_sh_q[7];

    always_comb begin
        rd_data_d = 8'h00;
        case (addr_q)
            7'h00: rd_data_d = ID_VALUE;
            7'h01: rd_data_d = {6'b0, ctrl_q};
            7'h02: rd_data_d = {6'b0, wave1_q};
            7'h03: rd_data_d = ftw1_sh_q[31:24];
            7'h04: rd_data_d = ftw1_sh_q[23:16];
            7'h05: rd_data_d = ftw1_sh_q[15:8];
            7'h06: rd_data_d = ftw1_sh_q[7:0];
            7'h07: rd_data_d = {6'b0, wave2_q};
            7'h08: rd_data_d = ftw2_sh_q[31:24];
            7'h09: rd_data_d = ftw2_sh_q[23:16];
            7'h0A: rd_data_d = ftw2_sh_q[15:8];
            7'h0B: rd_data_d = ftw2_sh_q[7:0];
            default: rd_data_d = 8'h00;
        endcase
    end

    // Writing the FTW LSB byte publishes the whole shadow word at once.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ctrl_q    <= '0;
            wave1_q   <= '0;
            wave2_q   <= '0;
            ftw1_sh_q <= '0;
            ftw1_q    <= '0;
            ftw2_sh_q <= '0;
            ftw2_q    <= '0;
        end else if (wr_en_q) begin
            case (wr_addr_q)
                7'h01: ctrl_q  <= wr_data_q[1:0];
                7'h02: wave1_q <= wr_data_q[1:0];
                7'h03: ftw1_sh_q[31:24] <= wr_data_q;
                7'h04: ftw1_sh_q[23:16] <= wr_data_q;
                7'h05: ftw1_sh_q[15:8]  <= wr_data_q;
                7'h06: begin
                    ftw1_sh_q[7:0] <= wr_data_q;
                    ftw1_q         <= {ftw1_sh_q[31:8], wr_data_q};
                end
                7'h07: wave2_q <= wr_data_q[1:0];
                7'h08: ftw2_sh_q[31:24] <= wr_data_q;
                7'h09: ftw2_sh_q[23:16] <= wr_data_q;
                7'h0A: ftw2_sh_q[15:8]  <= wr_data_q;
                7'h0B: begin
                    ftw2_sh_q[7:0] <= wr_data_q;
                    ftw2_q         <= {ftw2_sh_q[31:8], wr_data_q};
                end
                default: ;
            endcase
        end
    end

    function automatic logic [OUT_W-1:0] shape(input logic [OUT_W-1:0] p, input logic [1:0] wave);
        logic [OUT_W-1:0] r;
        case (wave)
            2'd0:    r = p;
            2'd1:    r = p[OUT_W-1] ? ~{p[OUT_W-2:0], 1'b0} : {p[OUT_W-2:0], 1'b0};
            2'd2:    r = {OUT_W{p[OUT_W-1]}};
            default: r = {1'b1, {(OUT_W-1){1'b0}}};
        endcase
        return r;
    endfunction

    assign acc1_d = acc1_q + ftw1_q;
    assign acc2_d = acc2_q + ftw2_q;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            acc1_q <= '0;
            acc2_q <= '0;
            ch1_q  <= '0;
            ch2_q  <= '0;
        end else begin
            acc1_q <= ctrl_q[0] ? acc1_d : 32'd0;
            acc2_q <= ctrl_q[1] ? acc2_d : 32'd0;
            ch1_q  <= ctrl_q[0] ? shape(acc1_q[31 -: OUT_W], wave1_q) : '0;
            ch2_q  <= ctrl_q[1] ? shape(acc2_q[31 -: OUT_W], wave2_q) : '0;
        end
    end

    assign dds_ch1_o = ch1_q;
    assign dds_ch2_o = ch2_q;

endmodule

// File: tb/tb_function_generator.sv
// Scoreboard bench for function_generator: stimulus pushes expected values,
// a monitor process pops and compares each observed DUT output.
`timescale 1ns/1ps
module tb_function_generator;

    localparam int OUT_W = 12;
    localparam int T_MISO = 0, T_CH1 = 1, T_CH2 = 2, T_PIN = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [OUT_W-1:0] ch1, ch2;
    logic             sck = 1'b0;
    logic             mosi = 1'b0;
    logic             miso;
    logic             cs = 1'b1;

    function_generator #(.OUT_W(OUT_W), .ID_VALUE(8'hA5)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .dds_ch1_o (ch1),
        .dds_ch2_o (ch2),
        .int_clk_i (sck),
        .int_mosi_i(mosi),
        .int_miso_o(miso),
        .int_cs_i  (cs)
    );

    always #10 clk = ~clk;

    typedef struct {int tag; logic [31:0] val;} item_t;
    item_t exp_q[$];
    item_t obs_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int idx      = 0;
    int half_ns  = 200;
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];

    function automatic string tag_name(input int t);
        case (t)
            T_MISO:  return "miso_byte";
            T_CH1:   return "dds_ch1";
            T_CH2:   return "dds_ch2";
            default: return "miso_pin";
        endcase
    endfunction

    function automatic void exp_push(input int t, input logic [31:0] v);
        exp_q.push_back('{tag: t, val: v});
    endfunction

    function automatic void obs_push(input int t, input logic [31:0] v);
        obs_q.push_back('{tag: t, val: v});
    endfunction

    function automatic logic [OUT_W-1:0] get_ch(input int t);
        return (t == T_CH1) ? ch1 : ch2;
    endfunction

    // Monitor: compares every observed output against the head of the expected queue.
    initial begin
        item_t o, e;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s: got 0x%0h with nothing expected", tag_name(o.tag), o.val);
                end else begin
                    e = exp_q.pop_front();
                    if (e.tag == o.tag && e.val === o.val)
                        n_pass++;
                    else
                        $display("FAIL %s: got 0x%0h, expected %s 0x%0h",
                                 tag_name(o.tag), o.val, tag_name(e.tag), e.val);
                end
            end
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            #(half_ns * 1ns);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            #(half_ns * 1ns);
            sck = 1'b0;
        end
    endtask

    task automatic cs_lo();
        cs = 1'b0;
        #(half_ns * 1ns);
    endtask

    task automatic cs_hi();
        #(half_ns * 1ns);
        cs = 1'b1;
        #(2 * half_ns * 1ns);
    endtask

    task automatic spi_frame(input int n);
        cs_lo();
        for (int b = 0; b < n; b++) spi_bits(tx_buf[b], 8, rx_buf[b]);
        cs_hi();
    endtask

    task automatic spi_wr(input logic [6:0] a, input logic [7:0] d);
        tx_buf[0] = {1'b1, a};
        tx_buf[1] = d;
        spi_frame(2);
    endtask

    // Caller pushes the expected reply bytes (ID first) before calling.
    task automatic spi_rd(input logic [6:0] a, input int n);
        tx_buf[0] = {1'b0, a};
        for (int b = 1; b <= n; b++) tx_buf[b] = 8'h00;
        spi_frame(n + 1);
        for (int b = 0; b <= n; b++) obs_push(T_MISO, {24'h0, rx_buf[b]});
    endtask

    task automatic rd_check(input logic [6:0] a, input logic [7:0] d0);
        exp_push(T_MISO, 32'hA5);
        exp_push(T_MISO, {24'h0, d0});
        spi_rd(a, 1);
    endtask

    // Aligns idx=0 to the first cycle showing transition pv -> cv on the channel.
    task automatic find(input int t, input logic [OUT_W-1:0] pv, input logic [OUT_W-1:0] cv);
        logic [OUT_W-1:0] prev, cur;
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        prev = get_ch(t);
        for (int i = 0; i < 600 && !hit; i++) begin
            @(negedge clk);
            cur = get_ch(t);
            if (prev == pv && cur == cv) hit = 1'b1;
            prev = cur;
        end
        idx = 0;
        if (!hit) begin
            n_checks++;
            $display("FAIL find_%s: transition 0x%0h->0x%0h not seen in 600 cycles",
                     tag_name(t), pv, cv);
        end
    endtask

    task automatic at_idx(input int k, input int t, input logic [31:0] ev);
        exp_push(t, ev);
        repeat (k - idx) @(negedge clk);
        idx = k;
        obs_push(t, {20'h0, get_ch(t)});
    endtask

    task automatic now_check(input int t, input logic [31:0] ev);
        exp_push(t, ev);
        @(negedge clk);
        if (t == T_PIN) obs_push(t, {31'h0, miso});
        else            obs_push(t, {20'h0, get_ch(t)});
    endtask

    initial begin
        // Reset held 10 us
        repeat (500) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        now_check(T_CH1, 0);
        now_check(T_CH2, 0);
        now_check(T_PIN, 0);

        // Single-byte frames at 1 MHz SCK
        half_ns = 500;
        exp_push(T_MISO, 32'hA5);
        tx_buf[0] = 8'hAA; spi_frame(1); obs_push(T_MISO, {24'h0, rx_buf[0]});
        exp_push(T_MISO, 32'hA5);
        tx_buf[0] = 8'h55; spi_frame(1); obs_push(T_MISO, {24'h0, rx_buf[0]});
        half_ns = 200;
        now_check(T_CH1, 0);
        now_check(T_CH2, 0);
        rd_check(7'h01, 8'h00);

        // CH1 FTW = 0x01000000 in one auto-increment frame
        tx_buf[0] = 8'h83; tx_buf[1] = 8'h01; tx_buf[2] = 8'h00;
        tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
        exp_push(T_MISO, 32'hA5);
        spi_frame(5);
        obs_push(T_MISO, {24'h0, rx_buf[0]});
        rd_check(7'h03, 8'h01);
        rd_check(7'h00, 8'hA5);
        now_check(T_CH1, 0);

        // Sawtooth: steps 0x010 per clock, period 256
        spi_wr(7'h01, 8'h01);
        find(T_CH1, 12'h000, 12'h010);
        at_idx(1, T_CH1, 32'h020);
        at_idx(2, T_CH1, 32'h030);
        at_idx(2, T_CH2, 32'h000);
        at_idx(255, T_CH1, 32'h000);
        at_idx(256, T_CH1, 32'h010);

        // Square
        spi_wr(7'h02, 8'h02);
        repeat (4) @(negedge clk);
        find(T_CH1, 12'h000, 12'hFFF);
        at_idx(127, T_CH1, 32'hFFF);
        at_idx(128, T_CH1, 32'h000);
        at_idx(255, T_CH1, 32'h000);
        at_idx(256, T_CH1, 32'hFFF);

        // Triangle
        spi_wr(7'h02, 8'h01);
        repeat (4) @(negedge clk);
        find(T_CH1, 12'h01F, 12'h000);
        at_idx(1, T_CH1, 32'h020);
        at_idx(127, T_CH1, 32'hFE0);
        at_idx(128, T_CH1, 32'hFFF);
        at_idx(129, T_CH1, 32'hFDF);
        at_idx(255, T_CH1, 32'h01F);

        // DC midscale
        spi_wr(7'h02, 8'h03);
        repeat (4) @(negedge clk);
        now_check(T_CH1, 32'h800);
        now_check(T_CH1, 32'h800);

        // Channel 2: FTW 0x00800000, sawtooth
        tx_buf[0] = 8'h88; tx_buf[1] = 8'h00; tx_buf[2] = 8'h80;
        tx_buf[3] = 8'h00; tx_buf[4] = 8'h00;
        spi_frame(5);
        spi_wr(7'h07, 8'h00);
        spi_wr(7'h01, 8'h03);
        find(T_CH2, 12'h000, 12'h008);
        at_idx(1, T_CH2, 32'h010);
        at_idx(2, T_CH2, 32'h018);
        at_idx(2, T_CH1, 32'h800);

        // Shadowing: MSB-only write must not reach the active FTW
        spi_wr(7'h08, 8'h01);
        rd_check(7'h08, 8'h01);
        rd_check(7'h0B, 8'h00);
        spi_wr(7'h01, 8'h01);
        repeat (4) @(negedge clk);
        now_check(T_CH2, 0);
        spi_wr(7'h01, 8'h03);
        find(T_CH2, 12'h000, 12'h008);
        at_idx(1, T_CH2, 32'h010);

        // RO / unmapped / multi-byte read
        spi_wr(7'h00, 8'hFF);
        rd_check(7'h00, 8'hA5);
        rd_check(7'h20, 8'h00);
        exp_push(T_MISO, 32'hA5); exp_push(T_MISO, 32'h01); exp_push(T_MISO, 32'h80);
        exp_push(T_MISO, 32'h00); exp_push(T_MISO, 32'h00);
        spi_rd(7'h08, 4);

        // Abort after 4 data bits
        cs_lo();
        spi_bits(8'h82, 8, rx_buf[0]);
        spi_bits(8'h00, 4, rx_buf[1]);
        cs_hi();
        rd_check(7'h02, 8'h03);

        // Reset in the middle of a frame, then a full byte while CS stays low
        cs_lo();
        spi_bits(8'h81, 8, rx_buf[0]);
        spi_bits(8'h00, 3, rx_buf[1]);
        @(negedge clk); rst = 1'b1;
        repeat (5) @(negedge clk); rst = 1'b0;
        spi_bits(8'h03, 8, rx_buf[1]);
        now_check(T_PIN, 0);
        cs_hi();
        repeat (4) @(negedge clk);
        now_check(T_CH1, 0);
        now_check(T_CH2, 0);
        rd_check(7'h01, 8'h00);
        spi_wr(7'h02, 8'h02);
        rd_check(7'h02, 8'h02);

        repeat (10) @(negedge clk);
        while (exp_q.size() > 0) begin
            item_t e;
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL %s: no output observed, expected 0x%0h", tag_name(e.tag), e.val);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
